// File: rtl/fifo_loop_stream_pkg.sv
// fifo_loop_stream_pkg: shared width helpers, default parameters and types
// for the looping FIFO.
// Optional feature macro used by the block: FIFO_LOOP_ERR_EN (sticky error flag).
package fifo_loop_stream_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 11;
    localparam int DEF_LOOPS = 3;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index 0..n-1; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [DEF_WIDTH-1:0]            data_t;
    typedef logic [ptr_w(DEF_DEPTH)-1:0]     ptr_t;
    typedef logic [cnt_w(DEF_DEPTH)-1:0]     cnt_t;

endpackage

// File: rtl/fifo_loop_stream_if.sv
// fifo_loop_stream_if: producer/consumer side signals of the looping FIFO.
//   push, push_data, pop          : requests from the master
//   pop_data, loop_idx            : head data (processed) and its loop index
//   empty, full, almost_*, count  : registered status
//   err                           : sticky error, only with FIFO_LOOP_ERR_EN
interface fifo_loop_stream_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 11,
    parameter int NUM_LOOPS  = 3
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(NUM_LOOPS + 1);

    logic                  push;
    logic [FIFO_WIDTH-1:0] push_data;
    logic                  pop;
    logic [FIFO_WIDTH-1:0] pop_data;
    logic [LW-1:0]         loop_idx;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
`ifdef FIFO_LOOP_ERR_EN
    logic                  err;

    modport master (output push, push_data, pop,
                    input  pop_data, loop_idx, empty, full, almost_full, almost_empty, count, err);
    modport slave  (input  push, push_data, pop,
                    output pop_data, loop_idx, empty, full, almost_full, almost_empty, count, err);
`else
    modport master (output push, push_data, pop,
                    input  pop_data, loop_idx, empty, full, almost_full, almost_empty, count);
    modport slave  (input  push, push_data, pop,
                    output pop_data, loop_idx, empty, full, almost_full, almost_empty, count);
`endif
endinterface

// File: rtl/fifo_loop_stream_mem.sv
// fifo_loop_stream_mem: DEPTH x WIDTH register array, one synchronous write
// port and one asynchronous read port. Contents are intentionally not reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : read data (combinational)
module fifo_loop_stream_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11,
    parameter int PW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_loop_stream.sv
// fifo_loop_stream: FIFO whose head word is presented NUM_LOOPS times before
// it retires. With ADD_MODE=1 the loop index is added to the head data.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : fifo_loop_stream_if.slave (push/pop requests, data, status)
// Optional feature macro: FIFO_LOOP_ERR_EN adds a sticky err flag set by
// push-while-full or pop-while-empty.
module fifo_loop_stream
    import fifo_loop_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_DEPTH,
    parameter int FIFO_WIDTH = DEF_WIDTH,
    parameter int NUM_LOOPS  = DEF_LOOPS,
    parameter int ADD_MODE   = 1,
    parameter int AF_LVL     = 6,
    parameter int AE_LVL     = 1
) (
    input  logic            clk,
    input  logic            rstn,
    fifo_loop_stream_if.slave bus
);
    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int CW = cnt_w(FIFO_DEPTH);
    localparam int LW = cnt_w(NUM_LOOPS);
    localparam logic AF_RST = (AF_LVL <= 0);
    localparam logic AE_RST = (AE_LVL >= 0);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] loop_q, loop_d;
    logic          empty_q, full_q, af_q, ae_q;
    logic          empty_d, full_d, af_d, ae_d;
    logic          push_ok, pop_ok, retire;
    logic [FIFO_WIDTH-1:0] head, proc;

    // Requests are qualified against the registered flags, so a push on a
    // full FIFO is dropped even when the head retires in the same cycle.
    assign push_ok = bus.push && !full_q;
    assign pop_ok  = bus.pop  && !empty_q;
    assign retire  = pop_ok && (loop_q == LW'(NUM_LOOPS - 1));

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        loop_d = loop_q;
        if (push_ok)
            wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (retire) begin
            loop_d = '0;
            rd_d   = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end else if (pop_ok) begin
            loop_d = loop_q + 1'b1;
        end
        cnt_d   = cnt_q + CW'(push_ok) - CW'(retire);
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CW'(FIFO_DEPTH));
        af_d    = (int'(cnt_d) >= AF_LVL);
        ae_d    = (int'(cnt_d) <= AE_LVL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            loop_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= AF_RST;
            ae_q    <= AE_RST;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    fifo_loop_stream_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(FIFO_WIDTH), .PW(PW)) u_mem (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (wr_q),
        .wdata_i (bus.push_data),
        .raddr_i (rd_q),
        .rdata_o (head)
    );

    generate
        if (ADD_MODE != 0) begin : g_add
            // Sum wraps at FIFO_WIDTH; loop index is zero-extended.
            assign proc = head + FIFO_WIDTH'(loop_q);
        end else begin : g_pass
            assign proc = head;
        end
    endgenerate

    assign bus.pop_data     = empty_q ? '0 : proc;
    assign bus.loop_idx     = loop_q;
    assign bus.count        = cnt_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;

`ifdef FIFO_LOOP_ERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_q | (bus.push && full_q) | (bus.pop && empty_q);
    end
    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_fifo_loop_stream.sv
module tb_fifo_loop_stream;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fifo_loop_stream_if #(.FIFO_DEPTH(8), .FIFO_WIDTH(11), .NUM_LOOPS(3)) ifa ();
    fifo_loop_stream_if #(.FIFO_DEPTH(8), .FIFO_WIDTH(11), .NUM_LOOPS(3)) ifb ();

    fifo_loop_stream #(.FIFO_DEPTH(8), .FIFO_WIDTH(11), .NUM_LOOPS(3), .ADD_MODE(1),
                       .AF_LVL(6), .AE_LVL(1)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    fifo_loop_stream #(.FIFO_DEPTH(8), .FIFO_WIDTH(11), .NUM_LOOPS(3), .ADD_MODE(0),
                       .AF_LVL(6), .AE_LVL(1)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic p, input logic [10:0] d, input logic r);
        ifa.push = p; ifa.push_data = d; ifa.pop = r;
        @(posedge clk); #1;
        ifa.push = 1'b0; ifa.pop = 1'b0;
    endtask

    task automatic step_b(input logic p, input logic [10:0] d, input logic r);
        ifb.push = p; ifb.push_data = d; ifb.pop = r;
        @(posedge clk); #1;
        ifb.push = 1'b0; ifb.pop = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [10:0] q [$];
    logic [10:0] nxt;

    initial begin
        ifa.push = 0; ifa.pop = 0; ifa.push_data = '0;
        ifb.push = 0; ifb.pop = 0; ifb.push_data = '0;
        do_reset();

        // reset state
        chk("rst_count", ifa.count, 0);
        chk("rst_empty", ifa.empty, 1);
        chk("rst_full", ifa.full, 0);
        chk("rst_ae", ifa.almost_empty, 1);
        chk("rst_af", ifa.almost_full, 0);
        chk("rst_loop", ifa.loop_idx, 0);
        chk("rst_data", ifa.pop_data, 0);

        // ADD_MODE wrap: 0x7FE + 0,1,2
        step_a(1, 11'h7FE, 0);
        chk("add_cnt", ifa.count, 1);
        chk("add_d0", ifa.pop_data, 11'h7FE);
        step_a(0, 0, 1);
        chk("add_d1", ifa.pop_data, 11'h7FF);
        chk("add_l1", ifa.loop_idx, 1);
        step_a(0, 0, 1);
        chk("add_d2", ifa.pop_data, 11'h000);
        chk("add_l2", ifa.loop_idx, 2);
        step_a(0, 0, 1);
        chk("add_empty", ifa.empty, 1);
        chk("add_cnt0", ifa.count, 0);
        chk("add_loop0", ifa.loop_idx, 0);
        chk("add_data0", ifa.pop_data, 0);
        // pop on empty ignored
        step_a(0, 0, 1);
        chk("popempty_cnt", ifa.count, 0);
        chk("popempty_loop", ifa.loop_idx, 0);

        // reset mid-stream: count=5, loop_idx=2
        for (int i = 0; i < 5; i++) step_a(1, 11'(i), 0);
        step_a(0, 0, 1);
        step_a(0, 0, 1);
        chk("mid_cnt5", ifa.count, 5);
        chk("mid_loop2", ifa.loop_idx, 2);
        rstn = 1'b0;
        #2;
        chk("mid_async_cnt", ifa.count, 0);
        @(posedge clk); #1;
        chk("mid_cnt", ifa.count, 0);
        chk("mid_empty", ifa.empty, 1);
        chk("mid_loop", ifa.loop_idx, 0);
        chk("mid_ae", ifa.almost_empty, 1);
        rstn = 1'b1;
        @(posedge clk); #1;

        // ADD_MODE=0: A,A,A,B,B,B
        step_b(1, 11'h123, 0);
        step_b(1, 11'h456, 0);
        chk("pass_cnt2", ifb.count, 2);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("pass_d%0d", i), ifb.pop_data, (i < 3) ? 11'h123 : 11'h456);
            step_b(0, 0, 1);
            if (i == 2) chk("pass_cnt1", ifb.count, 1);
            if (i == 5) chk("pass_cnt0", ifb.count, 0);
        end
        chk("pass_empty", ifb.empty, 1);
        // push+pop on empty: push lands, pop ignored
        step_b(1, 11'h00C, 1);
        chk("pp_empty_cnt", ifb.count, 1);
        chk("pp_empty_loop", ifb.loop_idx, 0);
        chk("pp_empty_data", ifb.pop_data, 11'h00C);
        step_b(0, 0, 1); step_b(0, 0, 1); step_b(0, 0, 1);
        chk("pp_drain", ifb.empty, 1);

        // fill / full / flags on dut_a
        for (int k = 1; k <= 8; k++) begin
            step_a(1, 11'(16 + k - 1), 0);
            chk($sformatf("fill_af%0d", k), ifa.almost_full, (k >= 6));
            chk($sformatf("fill_ae%0d", k), ifa.almost_empty, (k <= 1));
            chk($sformatf("fill_full%0d", k), ifa.full, (k == 8));
        end
        step_a(1, 11'h055, 0);
        chk("drop_cnt", ifa.count, 8);
        step_a(0, 0, 1);
        step_a(0, 0, 1);
        chk("full_loop2", ifa.loop_idx, 2);
        chk("full_d", ifa.pop_data, 11'h012);
        step_a(1, 11'h066, 1);
        chk("pr_cnt7", ifa.count, 7);
        chk("pr_full", ifa.full, 0);
        chk("pr_af", ifa.almost_full, 1);
        chk("pr_head", ifa.pop_data, 11'h011);
        for (int e = 1; e < 8; e++)
            for (int l = 0; l < 3; l++) begin
                chk($sformatf("drain_e%0d_l%0d", e, l), ifa.pop_data, 11'(16 + e + l));
                step_a(0, 0, 1);
            end
        chk("drain_empty", ifa.empty, 1);

        // wrap: hold count at 3 for 20 retire+push pairs
        nxt = 11'h200;
        for (int i = 0; i < 3; i++) begin
            step_b(1, nxt, 0); q.push_back(nxt); nxt++;
        end
        for (int it = 0; it < 20; it++) begin
            for (int l = 0; l < 3; l++) begin
                chk($sformatf("wrap_%0d_%0d", it, l), ifb.pop_data, q[0]);
                if (l == 2) begin
                    step_b(1, nxt, 1);
                    void'(q.pop_front()); q.push_back(nxt); nxt++;
                end else begin
                    step_b(0, 0, 1);
                end
            end
            chk($sformatf("wrap_cnt%0d", it), ifb.count, 3);
        end
        while (q.size() > 0) begin
            chk("wrap_tail", ifb.pop_data, q[0]);
            step_b(0, 0, 1); step_b(0, 0, 1); step_b(0, 0, 1);
            void'(q.pop_front());
        end
        chk("wrap_empty", ifb.empty, 1);

`ifdef FIFO_LOOP_ERR_EN
        do_reset();
        chk("err_rst", ifa.err, 0);
        step_a(0, 0, 1);
        chk("err_pop_empty", ifa.err, 1);
        chk("err_cnt", ifa.count, 0);
        step_a(1, 11'h001, 0);
        step_a(0, 0, 0);
        chk("err_sticky", ifa.err, 1);
        do_reset();
        chk("err_clr", ifa.err, 0);
        for (int k = 0; k < 8; k++) step_a(1, 11'(k), 0);
        chk("err_nofull", ifa.err, 0);
        step_a(1, 11'h07F, 0);
        chk("err_push_full", ifa.err, 1);
        chk("err_full_cnt", ifa.count, 8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
